// File: rtl/icache_pkg.sv
// icache_pkg: shared definitions for the instruction cache.
//   - default geometry (index bits, address and instruction widths)
//   - derived tag width and the all-zero instruction word
//   - refill FSM state encoding
package icache_pkg;

   localparam int ICACHE_INDEX_BITS = 7;
   localparam int INST_ADDR_W       = 32;
   localparam int INST_W            = 32;
   localparam int ICACHE_TAG_W      = INST_ADDR_W - ICACHE_INDEX_BITS - 2;

   localparam logic [INST_W-1:0] ZERO_WORD = '0;

   typedef enum logic [0:0] {
      ICACHE_IDLE  = 1'b0,
      ICACHE_FETCH = 1'b1
   } icache_state_e;

endpackage

// File: rtl/icache_if.sv
// icache_if: fetch and refill signal bundle around the instruction cache.
//   Fetch side : inst_req_in, inst_addr_in -> inst_valid_out, inst_out
//   Refill side: mem_req_out, mem_addr_out -> mem_valid_in, mem_data_in
// The slave modport is the cache; the master modport is its environment
// (IF stage plus memory controller).
interface icache_if
   import icache_pkg::*;
#(
   parameter int ADDR_WIDTH = INST_ADDR_W,
   parameter int DATA_WIDTH = INST_W
);
   logic                  inst_req_in;
   logic [ADDR_WIDTH-1:0] inst_addr_in;
   logic                  inst_valid_out;
   logic [DATA_WIDTH-1:0] inst_out;
   logic                  mem_req_out;
   logic [ADDR_WIDTH-1:0] mem_addr_out;
   logic                  mem_valid_in;
   logic [DATA_WIDTH-1:0] mem_data_in;

   modport slave (
      input  inst_req_in, inst_addr_in, mem_valid_in, mem_data_in,
      output inst_valid_out, inst_out, mem_req_out, mem_addr_out
   );

   modport master (
      output inst_req_in, inst_addr_in, mem_valid_in, mem_data_in,
      input  inst_valid_out, inst_out, mem_req_out, mem_addr_out
   );
endinterface

// File: rtl/icache_array.sv
// icache_array: valid/tag/data storage of the direct-mapped cache.
//   clk, rst   : clock; synchronous active-high reset clears every valid bit
//   rd_index   : asynchronous read index -> rd_valid, rd_tag, rd_data
//   wr_en      : synchronous write of (valid=1, wr_tag, wr_data) at wr_index
// Tag and data words carry no reset; only the valid bits need a known state.
module icache_array
   import icache_pkg::*;
#(
   parameter int INDEX_BITS = ICACHE_INDEX_BITS,
   parameter int TAG_W      = ICACHE_TAG_W,
   parameter int DATA_WIDTH = INST_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [INDEX_BITS-1:0] rd_index,
   output logic                  rd_valid,
   output logic [TAG_W-1:0]      rd_tag,
   output logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  wr_en,
   input  logic [INDEX_BITS-1:0] wr_index,
   input  logic [TAG_W-1:0]      wr_tag,
   input  logic [DATA_WIDTH-1:0] wr_data
);
   localparam int LINES = 1 << INDEX_BITS;

   logic [LINES-1:0]      valid_q;
   logic [TAG_W-1:0]      tag_mem  [LINES];
   logic [DATA_WIDTH-1:0] data_mem [LINES];

   assign rd_valid = valid_q[rd_index];
   assign rd_tag   = tag_mem[rd_index];
   assign rd_data  = data_mem[rd_index];

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else if (wr_en) begin
         valid_q[wr_index] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_mem[wr_index]  <= wr_tag;
         data_mem[wr_index] <= wr_data;
      end
   end
endmodule

// File: rtl/icache.sv
// icache: direct-mapped, read-only instruction cache, one word per line.
//   clk, rst : clock; synchronous active-high reset (overrides rdy)
//   rdy      : chip ready; low freezes every register and the array
//   bus      : icache_if.slave
//              fetch : inst_req_in/inst_addr_in -> inst_valid_out/inst_out
//              refill: mem_req_out/mem_addr_out (registered) <- mem_valid_in/mem_data_in
// Hits answer in the same cycle. A miss seen in IDLE launches a single
// one-word refill; the returning word is forwarded to IF when IF is still
// asking for the miss address, so the stall ends on the return cycle.
module icache
   import icache_pkg::*;
#(
   parameter int INDEX_BITS = ICACHE_INDEX_BITS,
   parameter int ADDR_WIDTH = INST_ADDR_W,
   parameter int DATA_WIDTH = INST_W
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     rdy,
   icache_if.slave  bus
);
   localparam int TAG_W = ADDR_WIDTH - INDEX_BITS - 2;

   logic [INDEX_BITS-1:0] rd_index;
   logic [TAG_W-1:0]      req_tag;
   logic                  line_valid;
   logic [TAG_W-1:0]      line_tag;
   logic [DATA_WIDTH-1:0] line_data;
   logic [ADDR_WIDTH-1:0] fetch_word;

   icache_state_e         state_q;
   logic                  mem_req_q;
   logic [ADDR_WIDTH-1:0] mem_addr_q;
   logic [ADDR_WIDTH-1:0] miss_addr_q;

   logic                  lookup_hit;
   logic                  hit;
   logic                  fill_now;
   logic                  bypass;

   assign rd_index   = bus.inst_addr_in[INDEX_BITS+1:2];
   assign req_tag    = bus.inst_addr_in[ADDR_WIDTH-1:INDEX_BITS+2];
   assign fetch_word = {bus.inst_addr_in[ADDR_WIDTH-1:2], 2'b00};

   assign lookup_hit = bus.inst_req_in && line_valid && (line_tag == req_tag);
   assign hit        = !rst && rdy && lookup_hit;

   // Refill data is accepted only while a request is outstanding; a return
   // for a request abandoned by reset lands in IDLE and is dropped.
   assign fill_now   = !rst && rdy && (state_q == ICACHE_FETCH) && bus.mem_valid_in;
   assign bypass     = fill_now && bus.inst_req_in && (fetch_word == miss_addr_q);

   icache_array #(
      .INDEX_BITS (INDEX_BITS),
      .TAG_W      (TAG_W),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_array (
      .clk      (clk),
      .rst      (rst),
      .rd_index (rd_index),
      .rd_valid (line_valid),
      .rd_tag   (line_tag),
      .rd_data  (line_data),
      .wr_en    (fill_now),
      .wr_index (miss_addr_q[INDEX_BITS+1:2]),
      .wr_tag   (miss_addr_q[ADDR_WIDTH-1:INDEX_BITS+2]),
      .wr_data  (bus.mem_data_in)
   );

   always_comb begin
      bus.inst_valid_out = 1'b0;
      bus.inst_out       = ZERO_WORD;
      if (hit) begin
         bus.inst_valid_out = 1'b1;
         bus.inst_out       = line_data;
      end else if (bypass) begin
         bus.inst_valid_out = 1'b1;
         bus.inst_out       = bus.mem_data_in;
      end
   end

   // Refill FSM. Only IDLE may launch a request, so a redirect during FETCH
   // waits for the outstanding word before its own miss is issued.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ICACHE_IDLE;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= '0;
         miss_addr_q <= '0;
      end else if (rdy) begin
         case (state_q)
            ICACHE_IDLE: begin
               if (bus.inst_req_in && !lookup_hit) begin
                  miss_addr_q <= fetch_word;
                  mem_addr_q  <= fetch_word;
                  mem_req_q   <= 1'b1;
                  state_q     <= ICACHE_FETCH;
               end
            end
            ICACHE_FETCH: begin
               if (bus.mem_valid_in) begin
                  mem_req_q <= 1'b0;
                  state_q   <= ICACHE_IDLE;
               end
            end
            default: begin
               state_q   <= ICACHE_IDLE;
               mem_req_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.mem_req_out  = mem_req_q;
   assign bus.mem_addr_out = mem_addr_q;
endmodule

// File: tb/tb_icache.sv
// tb_icache: directed bench for icache. Inputs change 1 ns after the rising
// edge; outputs are sampled on the falling edge.
module tb_icache;
   import icache_pkg::*;

   logic clk;
   logic rst;
   logic rdy;
   int   n_tests;
   int   n_fail;

   icache_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   icache dut (
      .clk (clk),
      .rst (rst),
      .rdy (rdy),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   // Miss on addr from IDLE, memory answers in the first FETCH cycle.
   task automatic fill(input string tag, input logic [31:0] addr, input logic [31:0] data);
      bus.inst_req_in  = 1'b1;
      bus.inst_addr_in = addr;
      settle();
      chk({tag, "_miss_valid"}, {31'd0, bus.inst_valid_out}, 32'd0);
      tick();
      bus.mem_valid_in = 1'b1;
      bus.mem_data_in  = data;
      settle();
      chk({tag, "_req"}, {31'd0, bus.mem_req_out}, 32'd1);
      chk({tag, "_req_addr"}, bus.mem_addr_out, addr);
      chk({tag, "_byp_valid"}, {31'd0, bus.inst_valid_out}, 32'd1);
      chk({tag, "_byp_data"}, bus.inst_out, data);
      tick();
      bus.mem_valid_in = 1'b0;
      bus.mem_data_in  = 32'd0;
   endtask

   logic [31:0] stream_addr [3];
   logic [31:0] stream_data [3];

   initial begin
      n_tests = 0;
      n_fail  = 0;
      stream_addr = '{32'h0, 32'h4, 32'h8};
      stream_data = '{32'h00000513, 32'h00100093, 32'h00200113};

      rst              = 1'b1;
      rdy              = 1'b1;
      bus.inst_req_in  = 1'b1;
      bus.inst_addr_in = 32'h0;
      bus.mem_valid_in = 1'b0;
      bus.mem_data_in  = 32'h0;
      tick();
      tick();

      // Reset state
      settle();
      chk("rst_valid", {31'd0, bus.inst_valid_out}, 32'd0);
      chk("rst_inst", bus.inst_out, 32'd0);
      chk("rst_mem_req", {31'd0, bus.mem_req_out}, 32'd0);
      chk("rst_mem_addr", bus.mem_addr_out, 32'd0);
      tick();
      rst = 1'b0;

      // 1. Cold miss, memory answers 3 cycles after mem_req_out rises
      settle();
      chk("t1_c0_valid", {31'd0, bus.inst_valid_out}, 32'd0);
      chk("t1_c0_req", {31'd0, bus.mem_req_out}, 32'd0);
      tick();
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("t1_wait_valid", {31'd0, bus.inst_valid_out}, 32'd0);
         chk("t1_wait_req", {31'd0, bus.mem_req_out}, 32'd1);
         chk("t1_wait_addr", bus.mem_addr_out, 32'h0);
         tick();
      end
      bus.mem_valid_in = 1'b1;
      bus.mem_data_in  = 32'h00000513;
      settle();
      chk("t1_byp_valid", {31'd0, bus.inst_valid_out}, 32'd1);
      chk("t1_byp_data", bus.inst_out, 32'h00000513);
      tick();
      bus.mem_valid_in = 1'b0;
      bus.mem_data_in  = 32'h0;
      for (int i = 0; i < 2; i++) begin
         settle();
         chk("t1_hit_valid", {31'd0, bus.inst_valid_out}, 32'd1);
         chk("t1_hit_data", bus.inst_out, 32'h00000513);
         chk("t1_hit_req", {31'd0, bus.mem_req_out}, 32'd0);
         tick();
      end

      // 2. Hit streaming over three filled words
      fill("t2_fill4", 32'h4, 32'h00100093);
      fill("t2_fill8", 32'h8, 32'h00200113);
      for (int i = 0; i < 3; i++) begin
         bus.inst_addr_in = stream_addr[i];
         settle();
         chk("t2_valid", {31'd0, bus.inst_valid_out}, 32'd1);
         chk("t2_data", bus.inst_out, stream_data[i]);
         chk("t2_req", {31'd0, bus.mem_req_out}, 32'd0);
         tick();
      end

      // 3. Conflict eviction: 0x200 shares index 0 with 0x000
      fill("t3_fillB", 32'h200, 32'hBBBB0001);
      bus.inst_addr_in = 32'h200;
      settle();
      chk("t3_hitB_valid", {31'd0, bus.inst_valid_out}, 32'd1);
      chk("t3_hitB_data", bus.inst_out, 32'hBBBB0001);
      tick();
      fill("t3_refillA", 32'h0, 32'h00000513);
      bus.inst_addr_in = 32'h200;
      settle();
      chk("t3_evictB_valid", {31'd0, bus.inst_valid_out}, 32'd0);
      bus.inst_req_in = 1'b0;
      tick();

      // 4. Redirect during FETCH: 0x100 and 0x300 share index 0x40
      bus.inst_req_in  = 1'b1;
      bus.inst_addr_in = 32'h100;
      settle();
      chk("t4_miss_valid", {31'd0, bus.inst_valid_out}, 32'd0);
      tick();
      bus.inst_addr_in = 32'h300;
      settle();
      chk("t4_redir_valid", {31'd0, bus.inst_valid_out}, 32'd0);
      chk("t4_redir_req", {31'd0, bus.mem_req_out}, 32'd1);
      chk("t4_redir_addr", bus.mem_addr_out, 32'h100);
      tick();
      bus.mem_valid_in = 1'b1;
      bus.mem_data_in  = 32'hC0DE0100;
      settle();
      chk("t4_nobyp_valid", {31'd0, bus.inst_valid_out}, 32'd0);
      chk("t4_nobyp_inst", bus.inst_out, 32'd0);
      tick();
      bus.mem_valid_in = 1'b0;
      bus.mem_data_in  = 32'h0;
      settle();
      chk("t4_idle_valid", {31'd0, bus.inst_valid_out}, 32'd0);
      chk("t4_idle_req", {31'd0, bus.mem_req_out}, 32'd0);
      tick();
      settle();
      chk("t4_req300", {31'd0, bus.mem_req_out}, 32'd1);
      chk("t4_addr300", bus.mem_addr_out, 32'h300);
      tick();
      bus.inst_addr_in = 32'h100;
      settle();
      chk("t4_hit100_valid", {31'd0, bus.inst_valid_out}, 32'd1);
      chk("t4_hit100_data", bus.inst_out, 32'hC0DE0100);
      chk("t4_hit100_req", {31'd0, bus.mem_req_out}, 32'd1);
      tick();
      bus.inst_addr_in = 32'h300;
      bus.mem_valid_in = 1'b1;
      bus.mem_data_in  = 32'hD0D00300;
      settle();
      chk("t4_byp300_valid", {31'd0, bus.inst_valid_out}, 32'd1);
      chk("t4_byp300_data", bus.inst_out, 32'hD0D00300);
      tick();
      bus.mem_valid_in = 1'b0;
      bus.mem_data_in  = 32'h0;

      // 5. Reset mid-FETCH
      bus.inst_addr_in = 32'h40;
      settle();
      chk("t5_miss_valid", {31'd0, bus.inst_valid_out}, 32'd0);
      tick();
      settle();
      chk("t5_req", {31'd0, bus.mem_req_out}, 32'd1);
      chk("t5_req_addr", bus.mem_addr_out, 32'h40);
      tick();
      rst              = 1'b1;
      bus.inst_addr_in = 32'h0;
      settle();
      chk("t5_rstcyc_valid", {31'd0, bus.inst_valid_out}, 32'd0);
      tick();
      rst              = 1'b0;
      bus.inst_req_in  = 1'b0;
      bus.mem_valid_in = 1'b1;
      bus.mem_data_in  = 32'hDEADBEEF;
      settle();
      chk("t5_after_req", {31'd0, bus.mem_req_out}, 32'd0);
      chk("t5_after_addr", bus.mem_addr_out, 32'd0);
      tick();
      bus.mem_valid_in = 1'b0;
      bus.mem_data_in  = 32'h0;
      bus.inst_req_in  = 1'b1;
      bus.inst_addr_in = 32'h40;
      settle();
      chk("t5_late_valid", {31'd0, bus.inst_valid_out}, 32'd0);
      tick();
      settle();
      chk("t5_rereq", {31'd0, bus.mem_req_out}, 32'd1);
      chk("t5_rereq_addr", bus.mem_addr_out, 32'h40);
      tick();
      bus.mem_valid_in = 1'b1;
      bus.mem_data_in  = 32'h0EEE0040;
      settle();
      chk("t5_byp_data", bus.inst_out, 32'h0EEE0040);
      tick();
      bus.mem_valid_in = 1'b0;
      bus.mem_data_in  = 32'h0;

      // 6. rdy low during FETCH with a refill pulse that must be ignored
      bus.inst_addr_in = 32'h80;
      settle();
      chk("t6_miss_valid", {31'd0, bus.inst_valid_out}, 32'd0);
      tick();
      settle();
      chk("t6_req", {31'd0, bus.mem_req_out}, 32'd1);
      tick();
      rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.mem_valid_in = (i == 1);
         bus.mem_data_in  = 32'hF00F0080;
         bus.inst_addr_in = (i == 2) ? 32'h40 : 32'h80;
         settle();
         chk("t6_frz_valid", {31'd0, bus.inst_valid_out}, 32'd0);
         chk("t6_frz_req", {31'd0, bus.mem_req_out}, 32'd1);
         chk("t6_frz_addr", bus.mem_addr_out, 32'h80);
         tick();
      end
      rdy              = 1'b1;
      bus.mem_valid_in = 1'b0;
      bus.inst_addr_in = 32'h80;
      settle();
      chk("t6_nofill_valid", {31'd0, bus.inst_valid_out}, 32'd0);
      chk("t6_held_req", {31'd0, bus.mem_req_out}, 32'd1);
      tick();
      bus.mem_valid_in = 1'b1;
      settle();
      chk("t6_byp_valid", {31'd0, bus.inst_valid_out}, 32'd1);
      chk("t6_byp_data", bus.inst_out, 32'hF00F0080);
      tick();
      bus.mem_valid_in = 1'b0;
      bus.mem_data_in  = 32'h0;
      settle();
      chk("t6_hit_valid", {31'd0, bus.inst_valid_out}, 32'd1);
      chk("t6_hit_data", bus.inst_out, 32'hF00F0080);
      chk("t6_hit_req", {31'd0, bus.mem_req_out}, 32'd0);
      tick();

      // Idle request: no output, no new miss
      bus.inst_req_in = 1'b0;
      settle();
      chk("idle_valid", {31'd0, bus.inst_valid_out}, 32'd0);
      chk("idle_inst", bus.inst_out, 32'd0);
      tick();
      settle();
      chk("idle_req", {31'd0, bus.mem_req_out}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
